// File: rtl/wts_pkg.sv
// Shared constants for the key event scheduler: command op encodings and slot geometry.
package wts_pkg;

  localparam logic [1:0] OP_NONE        = 2'd0;
  localparam logic [1:0] OP_KEY_ON      = 2'd1;
  localparam logic [1:0] OP_KEY_RELEASE = 2'd2;
  localparam logic [1:0] OP_KEY_OFF     = 2'd3;

  localparam int unsigned SLOT_NUM = 6;
  localparam logic [2:0]  SLOT_NOP = 3'd5;
  localparam int unsigned CH_NUM   = 5;

endpackage

// File: rtl/wts_key_event_scheduler.sv
// Rotates a six-slot schedule over channels A..E plus an idle slot, issuing one buffered
// key command per channel slot as a registered single-cycle pulse.
module wts_key_event_scheduler
  import wts_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [1:0]        cmd_op,
  output logic [2:0]        active,
  output logic              ch_a_key_on,
  output logic              ch_a_key_release,
  output logic              ch_a_key_off,
  output logic              ch_b_key_on,
  output logic              ch_b_key_release,
  output logic              ch_b_key_off,
  output logic              ch_c_key_on,
  output logic              ch_c_key_release,
  output logic              ch_c_key_off,
  output logic              ch_d_key_on,
  output logic              ch_d_key_release,
  output logic              ch_d_key_off,
  output logic              ch_e_key_on,
  output logic              ch_e_key_release,
  output logic              ch_e_key_off,
  output logic [CH_NUM-1:0] pending,
  output logic [CH_NUM-1:0] keyed
);

  logic [2:0]                   active_q, active_d;
  logic [CH_NUM-1:0][1:0]       pend_q, pend_d;
  logic [CH_NUM-1:0][2:0]       pulse_q, pulse_d;  // per channel {off, release, on}
  logic [CH_NUM-1:0]            keyed_q, keyed_d;
  logic [CH_NUM-1:0]            issue, write;
  logic                         cmd_accept;

  always_comb begin
    if (!enable) begin
      active_d = SLOT_NOP;
    end else if (active_q == 3'(SLOT_NUM - 1)) begin
      active_d = 3'd0;
    end else begin
      active_d = active_q + 3'd1;
    end
  end

  assign cmd_accept = cmd_valid && (cmd_ch < 3'(CH_NUM)) && (cmd_op != OP_NONE);

  // Issue looks only at pend_q, so a same-cycle write never bypasses into the pulse.
  // A key_off survives a later key_release unless that key_off is leaving right now.
  always_comb begin
    issue = '0;
    write = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      issue[i] = (active_d == 3'(i)) && (pend_q[i] != OP_NONE);
      write[i] = cmd_accept && (cmd_ch == 3'(i)) &&
                 !((pend_q[i] == OP_KEY_OFF) && (cmd_op == OP_KEY_RELEASE) && !issue[i]);
    end
  end

  always_comb begin
    pend_d  = pend_q;
    pulse_d = '0;
    keyed_d = keyed_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (issue[i]) begin
        pend_d[i] = OP_NONE;
        case (pend_q[i])
          OP_KEY_ON: begin
            pulse_d[i][0] = 1'b1;
            keyed_d[i]    = 1'b1;
          end
          OP_KEY_RELEASE: pulse_d[i][1] = 1'b1;
          OP_KEY_OFF: begin
            pulse_d[i][2] = 1'b1;
            keyed_d[i]    = 1'b0;
          end
          default: ;
        endcase
      end
      if (write[i]) begin
        pend_d[i] = cmd_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= SLOT_NOP;
      pend_q   <= '0;
      pulse_q  <= '0;
      keyed_q  <= '0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
      keyed_q  <= keyed_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      pending[i] = (pend_q[i] != OP_NONE);
    end
  end

  assign cmd_ready = 1'b1;
  assign active    = active_q;
  assign keyed     = keyed_q;

  assign ch_a_key_on      = pulse_q[0][0];
  assign ch_a_key_release = pulse_q[0][1];
  assign ch_a_key_off     = pulse_q[0][2];
  assign ch_b_key_on      = pulse_q[1][0];
  assign ch_b_key_release = pulse_q[1][1];
  assign ch_b_key_off     = pulse_q[1][2];
  assign ch_c_key_on      = pulse_q[2][0];
  assign ch_c_key_release = pulse_q[2][1];
  assign ch_c_key_off     = pulse_q[2][2];
  assign ch_d_key_on      = pulse_q[3][0];
  assign ch_d_key_release = pulse_q[3][1];
  assign ch_d_key_off     = pulse_q[3][2];
  assign ch_e_key_on      = pulse_q[4][0];
  assign ch_e_key_release = pulse_q[4][1];
  assign ch_e_key_off     = pulse_q[4][2];

endmodule

// File: tb/tb_wts_key_event_scheduler.sv
// Directed bench for the key event scheduler; expected values are hand-derived per scenario.
module tb_wts_key_event_scheduler;

  logic       clk = 1'b0;
  logic       reset, enable, cmd_valid, cmd_ready;
  logic [2:0] cmd_ch, active;
  logic [1:0] cmd_op;
  logic [4:0] pending, keyed;
  logic ch_a_key_on, ch_a_key_release, ch_a_key_off;
  logic ch_b_key_on, ch_b_key_release, ch_b_key_off;
  logic ch_c_key_on, ch_c_key_release, ch_c_key_off;
  logic ch_d_key_on, ch_d_key_release, ch_d_key_off;
  logic ch_e_key_on, ch_e_key_release, ch_e_key_off;
  logic [14:0] kv;  // bit 3*ch + (op-1)

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign kv = {ch_e_key_off, ch_e_key_release, ch_e_key_on,
               ch_d_key_off, ch_d_key_release, ch_d_key_on,
               ch_c_key_off, ch_c_key_release, ch_c_key_on,
               ch_b_key_off, ch_b_key_release, ch_b_key_on,
               ch_a_key_off, ch_a_key_release, ch_a_key_on};

  wts_key_event_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_ch           (cmd_ch),
    .cmd_op           (cmd_op),
    .active           (active),
    .ch_a_key_on      (ch_a_key_on),
    .ch_a_key_release (ch_a_key_release),
    .ch_a_key_off     (ch_a_key_off),
    .ch_b_key_on      (ch_b_key_on),
    .ch_b_key_release (ch_b_key_release),
    .ch_b_key_off     (ch_b_key_off),
    .ch_c_key_on      (ch_c_key_on),
    .ch_c_key_release (ch_c_key_release),
    .ch_c_key_off     (ch_c_key_off),
    .ch_d_key_on      (ch_d_key_on),
    .ch_d_key_release (ch_d_key_release),
    .ch_d_key_off     (ch_d_key_off),
    .ch_e_key_on      (ch_e_key_on),
    .ch_e_key_release (ch_e_key_release),
    .ch_e_key_off     (ch_e_key_off),
    .pending          (pending),
    .keyed            (keyed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] ch, input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_ch    = 3'd0;
    cmd_op    = 2'd0;
  endtask

  task automatic wait_active(input logic [2:0] v);
    int n = 0;
    while (active !== v && n < 12) begin
      tick();
      n++;
    end
    if (active !== v) check("wait_active", 32'(active), 32'(v));
  endtask

  function automatic logic [14:0] key_bit(input int ch, input int op);
    logic [14:0] one = 15'd1;
    return one << (3 * ch + op - 1);
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_ch = 3'd0; cmd_op = 2'd0;
    tick();
    tick();
    check("rst_active", 32'(active), 32'd5);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_keyed", 32'(keyed), 32'd0);
    check("rst_keys", 32'(kv), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Idle rotation
    reset = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      check("rot_active", 32'(active), 32'(k % 6));
      check("rot_keys", 32'(kv), 32'd0);
      tick();
    end
    check("rot_pending", 32'(pending), 32'd0);

    // key_on for A accepted at slot 2, issued at slot 0
    wait_active(3'd2);
    drive_cmd(3'd0, 2'd1);
    check("a_pend1", 32'(pending), 32'h01);
    tick();
    tick();
    check("a_pend3", 32'(pending), 32'h01);
    check("a_nokey", 32'(kv), 32'd0);
    tick();
    check("a_slot", 32'(active), 32'd0);
    check("a_pulse", 32'(kv), 32'(key_bit(0, 1)));
    check("a_pclr", 32'(pending), 32'd0);
    tick();
    check("a_keyed", 32'(keyed), 32'h01);
    check("a_once", 32'(kv), 32'd0);

    // key_off for D must not be overwritten by key_release
    wait_active(3'd4);
    drive_cmd(3'd3, 2'd3);
    drive_cmd(3'd3, 2'd2);
    check("d_pend", 32'(pending), 32'h08);
    tick();
    tick();
    check("d_early", 32'(kv), 32'd0);
    tick();
    check("d_slot", 32'(active), 32'd3);
    check("d_off", 32'(kv), 32'(key_bit(3, 3)));
    check("d_keyed", 32'(keyed[3]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("d_norel", 32'(kv), 32'd0);
    end

    // Invalid channel / op none are dropped
    drive_cmd(3'd6, 2'd1);
    drive_cmd(3'd1, 2'd0);
    for (int k = 0; k < 12; k++) begin
      check("drop_pend", 32'(pending), 32'd0);
      check("drop_keys", 32'(kv), 32'd0);
      tick();
    end

    // Burst while disabled, then release in slot order
    enable = 1'b0;
    tick();
    drive_cmd(3'd0, 2'd1);
    drive_cmd(3'd1, 2'd1);
    drive_cmd(3'd2, 2'd2);
    drive_cmd(3'd3, 2'd3);
    drive_cmd(3'd4, 2'd1);
    for (int k = 0; k < 10; k++) begin
      check("dis_active", 32'(active), 32'd5);
      check("dis_keys", 32'(kv), 32'd0);
      tick();
    end
    check("dis_pend", 32'(pending), 32'h1f);
    enable = 1'b1;
    tick();
    check("en_a", 32'(kv), 32'(key_bit(0, 1)));
    check("en_slot0", 32'(active), 32'd0);
    tick();
    check("en_b", 32'(kv), 32'(key_bit(1, 1)));
    tick();
    check("en_c", 32'(kv), 32'(key_bit(2, 2)));
    tick();
    check("en_d", 32'(kv), 32'(key_bit(3, 3)));
    tick();
    check("en_e", 32'(kv), 32'(key_bit(4, 1)));
    tick();
    check("en_nop", 32'(kv), 32'd0);
    check("en_pend", 32'(pending), 32'd0);
    check("en_keyed", 32'(keyed), 32'h13);

    // Write to an empty slot about to issue waits one full rotation
    wait_active(3'd1);
    drive_cmd(3'd2, 2'd1);
    check("byp_nokey", 32'(kv), 32'd0);
    check("byp_pend", 32'(pending), 32'h04);
    for (int k = 0; k < 5; k++) tick();
    check("byp_early", 32'(kv), 32'd0);
    tick();
    check("byp_late", 32'(kv), 32'(key_bit(2, 1)));
    check("byp_keyed", 32'(keyed), 32'h17);

    // Write to an occupied slot about to issue: old issues, new stays
    wait_active(3'd4);
    drive_cmd(3'd2, 2'd1);
    wait_active(3'd1);
    drive_cmd(3'd2, 2'd3);
    check("occ_old", 32'(kv), 32'(key_bit(2, 1)));
    check("occ_pend", 32'(pending), 32'h04);
    for (int k = 0; k < 6; k++) tick();
    check("occ_new", 32'(kv), 32'(key_bit(2, 3)));
    check("occ_keyed", 32'(keyed), 32'h13);

    // Reset mid-rotation discards pending E
    wait_active(3'd1);
    drive_cmd(3'd4, 2'd1);
    tick();
    check("rr_slot", 32'(active), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_active", 32'(active), 32'd5);
    check("rr_pend", 32'(pending), 32'd0);
    check("rr_keyed", 32'(keyed), 32'd0);
    tick();
    check("rr_first", 32'(active), 32'd0);
    for (int k = 0; k < 12; k++) begin
      check("rr_nokey", 32'(kv), 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wts_key_event_scheduler.md
WTS_KEY_EVENT_SCHEDULER -- requirements
Module: wts_key_event_scheduler

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide port `clk`, input, 1 bit: system clock, 21.477 MHz.
REQ-003 SHALL provide port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port `enable`, input, 1 bit: slot rotation enable.
REQ-005 SHALL provide the command request ports:
- `cmd_valid`, input, 1 bit: key command request.
- `cmd_ready`, output, 1 bit: command accepted.
- `cmd_ch`, input, 3 bits: target channel; 0..4 = A..E.
- `cmd_op`, input, 2 bits: 0 = none, 1 = key_on, 2 = key_release, 3 = key_off.
REQ-006 SHALL provide port `active`, output, 3 bits: slot index; 0..4 = channel, 5 = no operation.
REQ-007 SHALL provide ports `ch_a_key_on` .. `ch_e_key_off`, output, 15 x 1 bit: key_on/key_release/key_off pulse per channel A..E.
REQ-008 SHALL provide port `pending`, output, 5 bits: per-channel command-pending flags, bit0 = A.
REQ-009 SHALL provide port `keyed`, output, 5 bits: per-channel key-held state, bit0 = A.

Function
REQ-010 `active` SHALL be registered and advance 0,1,2,3,4,5,0,... by one per clk while `enable`=1.
REQ-011 While `enable`=0, `active` SHALL be forced to 5 and all key pulses SHALL be 0.
- When `enable` returns to 1, the sequence SHALL restart at 0.
REQ-012 `cmd_ready` SHALL be constantly 1; a command is accepted in any cycle with `cmd_valid`=1.
REQ-013 Accepted commands SHALL be dropped with no state change when `cmd_ch`>4 or `cmd_op`=0.
REQ-014 Each channel SHALL hold one 2-bit pending slot. A new valid command SHALL overwrite it (last writer wins), except that a pending key_off SHALL NOT be overwritten by key_release.
REQ-015 Key pulses SHALL be registered. In the cycle where `active`=ch and pending[ch]!=0, exactly the matching ch_x_key_* output SHALL be 1, for exactly one cycle, and pending[ch] SHALL clear.
REQ-016 The issue decision for a slot SHALL use pending state as of the preceding cycle.
REQ-017 A same-cycle write to the channel about to be issued SHALL NOT bypass:
- If the slot was empty, the new command SHALL issue one rotation later (6 cycles).
- If the slot was occupied, the old command SHALL issue and the new command SHALL remain pending.
REQ-018 At most one of the 15 key outputs SHALL be 1 in any cycle.
REQ-019 No key output SHALL be 1 while `active`=5.
REQ-020 `keyed[ch]` SHALL set on issued key_on, clear on issued key_off, and be unchanged by key_release.
REQ-021 Worst-case latency from acceptance to pulse SHALL be 7 enabled cycles.
REQ-022 Commands accepted while `enable`=0 SHALL be held until enabled.

Reset
REQ-023 With `reset`=1 at a clk edge, the block SHALL set:
- `active`=5;
- `pending`=0 and `keyed`=0;
- all key pulses = 0.
`cmd_ready` SHALL remain 1.
REQ-024 Reset asserted mid-rotation or mid-pulse SHALL discard all pending commands with no pulse emitted.
- The first slot after reset release with `enable`=1 SHALL be 0.

Structure
REQ-025 Shared package wts_pkg SHALL hold:
- the op encoding constants: OP_NONE, OP_KEY_ON, OP_KEY_RELEASE, OP_KEY_OFF;
- the slot constants: SLOT_NUM=6, SLOT_NOP=5, CH_NUM=5.
REQ-026 The block SHALL be a single module with no sub-module. The slot counter and pending array are inline.

Verification
REQ-027 Reset released, `enable`=1, no commands -> `active` = 0,1,2,3,4,5,0...; all key outputs 0; `pending`=0.
REQ-028 cmd_ch=0, cmd_op=1 accepted while `active`=2 -> `pending`=5'b00001 until `ch_a_key_on`=1 with `active`=0 (4 cycles later); `keyed`=5'b00001 the next cycle; `pending`=0.
REQ-029 cmd_ch=3, op=3, then cmd_ch=3, op=2 before issue -> single `ch_d_key_off` pulse at `active`=3; no release pulse; `keyed[3]`=0.
REQ-030 cmd_ch=6 op=1, and cmd_ch=1 op=0 -> dropped; `pending`=0; no pulses over 12 cycles.
REQ-031 Commands for all five channels in one burst, `enable`=0 for 10 cycles, then `enable`=1 -> `active`=5 and no pulses while disabled; then pulses A,B,C,D,E on consecutive cycles starting at `active`=0.
REQ-032 cmd_ch=4 op=1 pending, then `reset`=1 for 1 cycle while `active`=3 -> no `ch_e_key_on` pulse ever; `pending`=0; `active`=5 after reset.
